// File: rtl/processor_pkg.sv
// Shared processor constants and the store-sequencer state encoding.
package processor_pkg;

    localparam int DEF_WORDSIZE = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DEPTH    = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/rf_store_sequencer.sv
// Copies a block of register file words into data memory,
// one word every two cycles, using RF read port A and the DM write port.
module rf_store_sequencer
    import processor_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   rf_base,
    input  logic [ADDR_W-1:0]   dm_base,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   rf_addr_a,
    input  logic [WORDSIZE-1:0] rf_data_a,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [WORDSIZE-1:0] dm_data_input,
    output logic                dm_write_enable,
    output logic                dm_read,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   rf_ptr_q, rf_ptr_d;
    logic [ADDR_W-1:0]   dm_ptr_q, dm_ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d   = state_q;
        rf_ptr_d  = rf_ptr_q;
        dm_ptr_d  = dm_ptr_q;
        rem_d     = rem_q;
        rf_addr_d = rf_addr_q;
        dm_addr_d = dm_addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rf_ptr_d = rf_base;
                    dm_ptr_d = dm_base;
                    rem_d    = (count > DEPTH_CNT) ? DEPTH_CNT : count;
                    if (count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        rf_addr_d = rf_base;
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                wdata_d   = rf_data_a;
                dm_addr_d = dm_ptr_q;
                we_d      = 1'b1;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                // Pointers wrap naturally at DEPTH through ADDR_W-bit overflow
                rf_ptr_d = rf_ptr_q + 1'b1;
                dm_ptr_d = dm_ptr_q + 1'b1;
                rem_d    = rem_q - ONE_CNT;
                if (rem_q > ONE_CNT) begin
                    state_d   = ST_READ;
                    rf_addr_d = rf_ptr_q + 1'b1;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rf_ptr_q  <= '0;
            dm_ptr_q  <= '0;
            rem_q     <= '0;
            rf_addr_q <= '0;
            dm_addr_q <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rf_ptr_q  <= rf_ptr_d;
            dm_ptr_q  <= dm_ptr_d;
            rem_q     <= rem_d;
            rf_addr_q <= rf_addr_d;
            dm_addr_q <= dm_addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rf_addr_a       = rf_addr_q;
    assign dm_addr         = dm_addr_q;
    assign dm_data_input   = wdata_q;
    assign dm_write_enable = we_q;
    assign dm_read         = 1'b0;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_rf_store_sequencer.sv
// Randomized bench for rf_store_sequencer with behavioural RF/DM endpoints
// and a per-cycle expectation derived from the block-copy rules.
module tb_rf_store_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rf_base;
    logic [4:0]  dm_base;
    logic [5:0]  count;
    logic [4:0]  rf_addr_a;
    logic [63:0] rf_data_a;
    logic [4:0]  dm_addr;
    logic [63:0] dm_data_input;
    logic        dm_write_enable;
    logic        dm_read;
    logic        busy;
    logic        done;

    logic [63:0] rf_mem [32];
    logic [63:0] dm_mem [32];
    logic [63:0] exp_dm [32];

    int n_chk  = 0;
    int n_pass = 0;

    rf_store_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rf_base         (rf_base),
        .dm_base         (dm_base),
        .count           (count),
        .rf_addr_a       (rf_addr_a),
        .rf_data_a       (rf_data_a),
        .dm_addr         (dm_addr),
        .dm_data_input   (dm_data_input),
        .dm_write_enable (dm_write_enable),
        .dm_read         (dm_read),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    assign rf_data_a = rf_mem[rf_addr_a];

    always @(posedge clk) begin
        if (dm_write_enable) dm_mem[dm_addr] <= dm_data_input;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_we"}, dm_write_enable, 0);
        check({tag, "_rd"}, dm_read, 0);
        check({tag, "_rfa"}, rf_addr_a, 0);
        check({tag, "_dma"}, dm_addr, 0);
        check({tag, "_dmd"}, dm_data_input, 0);
    endtask

    task automatic scramble_inputs();
        rf_base = 5'($urandom);
        dm_base = 5'($urandom);
        count   = 6'($urandom_range(40, 0));
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++)
            check($sformatf("dm[%0d]", i), dm_mem[i], exp_dm[i]);
    endtask

    // Cycle k=1 starts at the edge sampling start; word i is written
    // in cycle 2i+2, the RF is addressed in cycle 2i+1, DONE is 2N+1.
    task automatic run_txn(input int rb, input int db, input int cnt,
                           input int rst_at, input bit noise);
        int n, nw, last, w;
        n    = (cnt > 32) ? 32 : cnt;
        nw   = (rst_at > 0) ? rst_at / 2 : n;
        last = (rst_at > 0) ? rst_at : 2 * n + 1;
        for (int i = 0; i < nw; i++)
            exp_dm[(db + i) % 32] = rf_mem[(rb + i) % 32];
        start   = 1'b1;
        rf_base = 5'(rb);
        dm_base = 5'(db);
        count   = 6'(cnt);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check("busy", busy, 64'(n > 0 && k <= 2 * n));
            check("done", done, 64'(k == 2 * n + 1));
            check("we", dm_write_enable, 64'(k % 2 == 0 && k <= 2 * n));
            check("dm_read", dm_read, 0);
            if (k % 2 == 1 && k <= 2 * n)
                check("rf_addr", rf_addr_a, 64'((rb + (k - 1) / 2) % 32));
            if (k % 2 == 0 && k <= 2 * n) begin
                w = k / 2 - 1;
                check("dm_addr", dm_addr, 64'((db + w) % 32));
                check("wdata", dm_data_input, rf_mem[(rb + w) % 32]);
            end
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            start = noise && ($urandom_range(3, 0) == 0 || k == 10);
            scramble_inputs();
        end
        if (rst_at > 0) begin
            @(negedge clk);
            check_idle_zero("post_rst");
            rst = 1'b0;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_we", dm_write_enable, 0);
        end
        check_mem();
    endtask

    task automatic fill_rf();
        for (int i = 0; i < 32; i++)
            rf_mem[i] = {$urandom, $urandom};
    endtask

    initial begin
        fill_rf();
        for (int i = 0; i < 32; i++) begin
            dm_mem[i] = {$urandom, $urandom};
            exp_dm[i] = dm_mem[i];
        end
        rst     = 1'b1;
        start   = 1'b1;
        rf_base = 5'd1;
        dm_base = 5'd2;
        count   = 6'd5;
        repeat (3) begin
            @(negedge clk);
            check_idle_zero("reset");
        end
        check_mem();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        rf_mem[3] = 64'hDEADBEEF_00000001;
        run_txn(3, 7, 1, 0, 1'b0);
        check("single_dm7", dm_mem[7], 64'hDEADBEEF_00000001);

        fill_rf();
        run_txn(30, 31, 3, 0, 1'b0);
        check("wrap_dm0", dm_mem[0], rf_mem[31]);

        run_txn(12, 20, 0, 0, 1'b0);

        fill_rf();
        run_txn(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                40, 0, 1'b1);

        fill_rf();
        run_txn(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                8, 6, 1'b1);

        for (int t = 0; t < 25; t++) begin
            fill_rf();
            run_txn(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                    int'($urandom_range(40, 0)), 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
